// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared definitions for the convolution pipeline stages.
//             Sample width, maximum frame size, the pooling FSM state type,
//             and a signed max helper reused by downstream stages.
//  Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int CONV_DATA_W   = 16;
  localparam int CONV_MAX_SIZE = 15;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pool_state_t;

  // Signed maximum; ties return the (identical) value.
  function automatic logic signed [CONV_DATA_W-1:0] smax(
    input logic signed [CONV_DATA_W-1:0] a,
    input logic signed [CONV_DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_maxpool_linebuf.sv
`default_nettype none
// ============================================================================
//  Module   : conv_maxpool_linebuf
//  Purpose  : Line buffer holding one row of horizontal pair maxima.
//             Synchronous write, asynchronous read, no reset on storage.
//  Ports    : clk            - clock
//             we/waddr/wdata - write port
//             raddr/rdata    - combinational read port
//  Revision : 1.0 - initial release
// ============================================================================
module conv_maxpool_linebuf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 7,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // One extra bit so DEPTH is representable even when it equals 2**AW.
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < C_DEPTH)) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = ({1'b0, raddr} < C_DEPTH) ? r_mem[raddr] : '0;

endmodule
`default_nettype wire

// File: rtl/conv_maxpool.sv
`default_nettype none
// ============================================================================
//  Module   : conv_maxpool
//  Purpose  : 2x2 stride-2 max pooling on a raster-order N x N stream of
//             signed samples. Keeps one line of horizontal pair maxima;
//             emits floor(N/2)^2 pooled samples one cycle after the beat
//             that completes each 2x2 window.
//  Ports    : clk, rst_n (async, active-low)
//             cfg_valid, image_size - frame configuration (N sampled in IDLE)
//             in_valid, in_data     - input sample stream, no backpressure
//             out_valid, out_data   - pooled output (data 0 when not valid)
//             busy                  - high while a frame is in progress
//             frame_done            - pulse after the last sample of a frame
//             cfg_err               - pulse when a configuration has N < 2
//  Revision : 1.0 - initial release
// ============================================================================
module conv_maxpool
  import conv_pkg::*;
#(
  parameter int DATA_W   = CONV_DATA_W,
  parameter int MAX_SIZE = CONV_MAX_SIZE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  input  logic [3:0]               image_size,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     cfg_err
);

  localparam int LB_DEPTH = MAX_SIZE / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  pool_state_t r_state, w_state_nxt;

  logic [3:0]               r_size, r_row, r_col;
  logic signed [DATA_W-1:0] r_held;
  logic signed [DATA_W-1:0] w_pair, w_result;
  logic [DATA_W-1:0]        w_lb_rdata;
  logic [LB_AW-1:0]         w_lb_addr;
  logic                     w_accept, w_cfg_ok, w_col_last, w_row_last;
  logic                     w_frame_last, w_lb_we, w_emit;
  logic                     r_out_valid, r_frame_done, r_cfg_err;
  logic signed [DATA_W-1:0] r_out_data;

  // Samples only count while running; this also drops the beat that
  // coincides with the accepting cfg_valid.
  assign w_accept     = (r_state == ST_RUN) && in_valid;
  assign w_cfg_ok     = cfg_valid && (image_size >= 4'd2);
  assign w_col_last   = (r_col == r_size - 4'd1);
  assign w_row_last   = (r_row == r_size - 4'd1);
  assign w_frame_last = w_accept && w_col_last && w_row_last;

  // Odd columns close a horizontal pair; even rows store it, odd rows
  // combine it with the stored pair from the row above. For odd N the
  // trailing column/row never reach an odd-row/odd-col closing beat.
  assign w_lb_addr = LB_AW'(r_col >> 1);
  assign w_lb_we   = w_accept && r_col[0] && !r_row[0];
  assign w_emit    = w_accept && r_col[0] && r_row[0];
  assign w_pair    = smax(r_held, in_data);
  assign w_result  = smax(w_pair, $signed(w_lb_rdata));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_cfg_ok)     w_state_nxt = ST_RUN;
      ST_RUN:  if (w_frame_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- Counters and pair register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_size <= '0;
      r_row  <= '0;
      r_col  <= '0;
      r_held <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_cfg_ok) begin
        r_size <= image_size;
        r_row  <= '0;
        r_col  <= '0;
      end else if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? 4'd0 : r_row + 4'd1;
        end else begin
          r_col <= r_col + 4'd1;
        end
      end
      if (w_accept && !r_col[0]) begin
        r_held <= in_data;
      end
    end
  end

  // ---------------- Registered outputs ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_out_valid  <= w_emit;
      r_out_data   <= w_emit ? w_result : '0;
      r_frame_done <= w_frame_last;
      r_cfg_err    <= (r_state == ST_IDLE) && cfg_valid && (image_size < 4'd2);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;
  assign cfg_err    = r_cfg_err;
  assign busy       = (r_state == ST_RUN);

  conv_maxpool_linebuf #(
    .DATA_W (DATA_W),
    .DEPTH  (LB_DEPTH),
    .AW     (LB_AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (w_lb_we),
    .waddr (w_lb_addr),
    .wdata (w_pair),
    .raddr (w_lb_addr),
    .rdata (w_lb_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv_maxpool.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_maxpool
//  Purpose  : Directed self-checking bench for conv_maxpool.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_maxpool;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cfg_valid;
  logic [3:0]         image_size;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               busy;
  logic               frame_done;
  logic               cfg_err;

  int n_vec = 0;
  int n_err = 0;

  logic signed [15:0] img [0:224];
  logic signed [15:0] exp_q [$];

  always #5 clk = ~clk;

  conv_maxpool dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .image_size (image_size),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Configuration pulse; a sample strobed in the same cycle must be dropped.
  task automatic cfg(input int n);
    cfg_valid  = 1'b1;
    image_size = 4'(n);
    in_valid   = 1'b1;
    in_data    = 16'sh7fff;
    tick();
    cfg_valid  = 1'b0;
    in_valid   = 1'b0;
  endtask

  // Streams nbeats samples of img for an n x n frame; expected outputs are
  // taken in order from exp_q at every odd-row/odd-col closing beat.
  task automatic run_frame(input int n, input int nbeats, input bit gaps, input int inj_at);
    int r, c;
    bit ev;
    logic signed [15:0] ed;
    for (int k = 0; k < nbeats; k++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          tick();
          chk("gap_out_valid", out_valid, 1'b0);
          chk("gap_out_data", out_data, 16'sd0);
        end
      end
      r = k / n;
      c = k % n;
      in_valid = 1'b1;
      in_data  = img[k];
      if (k == inj_at) begin
        cfg_valid  = 1'b1;
        image_size = 4'd7;
      end
      tick();
      in_valid  = 1'b0;
      cfg_valid = 1'b0;
      ev = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (n / 2)) && (c < 2 * (n / 2));
      ed = 16'sd0;
      if (ev) begin
        if (exp_q.size() > 0) ed = exp_q.pop_front();
      end
      chk($sformatf("out_valid[%0d]", k), out_valid, ev);
      chk($sformatf("out_data[%0d]", k), out_data, ed);
      chk($sformatf("frame_done[%0d]", k), frame_done, (k == n * n - 1));
      chk($sformatf("busy[%0d]", k), busy, (k != n * n - 1));
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_valid  = 1'b0;
    image_size = 4'd0;
    in_valid   = 1'b0;
    in_data    = 16'sd0;
    tick();
    tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'sd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_cfg_err", cfg_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // ---- N=4 ramp 0..15 ----
    cfg(4);
    chk("t1_busy", busy, 1'b1);
    chk("t1_cfg_err", cfg_err, 1'b0);
    for (int i = 0; i < 16; i++) img[i] = 16'(i);
    exp_q = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
    run_frame(4, 16, 1'b0, -1);
    chk("t1_outs_left", exp_q.size(), 0);

    // ---- N=5 back-to-back, descending negatives ----
    cfg(5);
    chk("t2_busy", busy, 1'b1);
    chk("t2_frame_done_cleared", frame_done, 1'b0);
    for (int i = 0; i < 25; i++) img[i] = 16'(-i);
    exp_q = '{16'sd0, -16'sd2, -16'sd10, -16'sd12};
    run_frame(5, 25, 1'b0, -1);
    chk("t2_outs_left", exp_q.size(), 0);
    tick();
    chk("t2_idle_frame_done", frame_done, 1'b0);

    // ---- N=4 extremes ----
    cfg(4);
    for (int i = 0; i < 16; i++) img[i] = 16'sh8000;
    img[11] = 16'sh7fff;
    exp_q = '{16'sh8000, 16'sh8000, 16'sh8000, 16'sh7fff};
    run_frame(4, 16, 1'b0, -1);
    chk("t3_outs_left", exp_q.size(), 0);

    // ---- N=6 random data with random gaps, golden max-pool ----
    cfg(6);
    for (int i = 0; i < 36; i++) begin
      logic [31:0] t;
      t = $urandom;
      img[i] = t[15:0];
    end
    img[0]  = 16'sh8000;
    img[7]  = 16'sh7fff;
    img[20] = 16'sh8000;
    img[21] = 16'sh8000;
    img[26] = 16'sh8000;
    img[27] = 16'sh8000;
    exp_q = {};
    for (int pr = 0; pr < 3; pr++) begin
      for (int pc = 0; pc < 3; pc++) begin
        logic signed [15:0] m;
        int b;
        b = 2 * pr * 6 + 2 * pc;
        m = img[b];
        if (img[b + 1] > m) m = img[b + 1];
        if (img[b + 6] > m) m = img[b + 6];
        if (img[b + 7] > m) m = img[b + 7];
        exp_q.push_back(m);
      end
    end
    run_frame(6, 36, 1'b1, -1);
    chk("t4_outs_left", exp_q.size(), 0);

    // ---- N=1 rejected, then N=7 ignored during an N=4 frame ----
    cfg(1);
    chk("t5_cfg_err", cfg_err, 1'b1);
    chk("t5_busy", busy, 1'b0);
    tick();
    chk("t5_cfg_err_pulse", cfg_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(100 + i);
      tick();
      chk("t5_idle_out_valid", out_valid, 1'b0);
      chk("t5_idle_busy", busy, 1'b0);
    end
    in_valid = 1'b0;
    cfg(4);
    for (int i = 0; i < 16; i++) img[i] = 16'(15 - i);
    exp_q = '{16'sd15, 16'sd13, 16'sd7, 16'sd5};
    run_frame(4, 16, 1'b0, 5);
    chk("t5_outs_left", exp_q.size(), 0);
    tick();
    chk("t5_after_busy", busy, 1'b0);
    chk("t5_after_cfg_err", cfg_err, 1'b0);

    // ---- reset at beat 9 of an N=4 frame, then N=2 ----
    cfg(4);
    for (int i = 0; i < 16; i++) img[i] = 16'(i);
    exp_q = '{16'sd5, 16'sd7};
    run_frame(4, 9, 1'b0, -1);
    chk("t6_pre_busy", busy, 1'b1);
    in_valid = 1'b1;
    in_data  = img[9];
    rst_n    = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_out_valid", out_valid, 1'b0);
    chk("t6_rst_out_data", out_data, 16'sd0);
    chk("t6_rst_frame_done", frame_done, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 10; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = img[i];
      tick();
      chk("t6_discard_out_valid", out_valid, 1'b0);
      chk("t6_discard_frame_done", frame_done, 1'b0);
    end
    in_valid = 1'b0;
    cfg(2);
    img[0] = 16'sd3;
    img[1] = -16'sd1;
    img[2] = 16'sd8;
    img[3] = 16'sd2;
    exp_q = '{16'sd8};
    run_frame(2, 4, 1'b0, -1);
    chk("t6_outs_left", exp_q.size(), 0);
    tick();
    chk("t6_final_out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
